// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl upload (read-back) path.
// Holds the upload FSM encoding, the ioctl address width and the byte returned outside the window.
package ioctl_pkg;

  localparam int         IOCTL_AW  = 25;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE,
    ST_READY,
    ST_FETCH,
    ST_LAT,
    ST_RELEASE
  } upload_state_e;

endpackage

// File: rtl/ioctl_upload_server_if.sv
// hps_io side of the ioctl upload channel: session/index/address/strobe in, byte/wait back.
// master = hps_io (issues reads), slave = the upload responder.
interface ioctl_upload_server_if;
  import ioctl_pkg::*;

  logic                ioctl_upload;
  logic [7:0]          ioctl_index;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic                ioctl_rd;
  logic [7:0]          ioctl_din;
  logic                ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
    output ioctl_din, ioctl_wait
  );

endinterface

// File: rtl/upload_pause_arb.sv
// CPU pause handshake and RAM-port ownership for a HPS-side RAM accessor; registered, 1-cycle command-to-output.
// hold_o flags an external un-pause while the port is owned so the owner can freeze.
module upload_pause_arb (
  input  logic clk_i,
  input  logic rst_i,
  input  logic acq_i,
  input  logic own_i,
  input  logic rel_i,
  input  logic done_i,
  input  logic paused_i,
  output logic pause_req_o,
  output logic ram_access_o,
  output logic hold_o
);

  logic pause_req_q;
  logic access_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pause_req_q <= 1'b0;
      access_q    <= 1'b0;
    end else begin
      if (acq_i)       pause_req_q <= 1'b1;
      else if (done_i) pause_req_q <= 1'b0;
      if (own_i)       access_q <= 1'b1;
      else if (rel_i)  access_q <= 1'b0;
    end
  end

  assign pause_req_o  = pause_req_q;
  assign ram_access_o = access_q;
  assign hold_o       = access_q & ~paused_i;

endmodule

// File: rtl/ioctl_upload_server.sv
// Serves ioctl upload reads from a paused game RAM window; byte valid RD_LAT+1 cycles after ioctl_rd, ioctl_wait stalls hps_io.
// UPLOAD_DIRTY_REQ_EN adds cpu_wr/cpu_addr tracking that raises ioctl_upload_req when the window was written.
module ioctl_upload_server
  import ioctl_pkg::*;
#(
  parameter int              AW     = 16,
  parameter logic [AW-1:0]   BASE   = 16'h6000,
  parameter int              LEN    = 1024,
  parameter logic [7:0]      INDEX  = 8'd4,
  parameter int              RD_LAT = 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  ioctl_upload_server_if.slave io,
  output logic                 pause_req,
  input  logic                 paused,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_rd,
  input  logic [7:0]           ram_data,
  output logic                 ram_access
`ifdef UPLOAD_DIRTY_REQ_EN
  ,
  input  logic                 cpu_wr,
  input  logic [AW-1:0]        cpu_addr,
  output logic                 ioctl_upload_req
`endif
);

  localparam int                  CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IOCTL_AW-1:0] LEN_A = IOCTL_AW'(LEN);

  upload_state_e       state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [IOCTL_AW-1:0] pend_addr_q, pend_addr_d;
  logic                wait_q, wait_d;
  logic [7:0]          din_q, din_d;
  logic [AW-1:0]       ram_addr_q;
  logic                sel, hold, serve, in_range;
  logic [IOCTL_AW-1:0] req_addr;
  logic                acq, own, rel, done;

  assign sel      = io.ioctl_upload & (io.ioctl_index == INDEX);
  assign req_addr = pend_q ? pend_addr_q : io.ioctl_addr;
  assign in_range = req_addr < LEN_A;
  // A latched strobe is always older than a live one, so it is served first.
  assign serve    = (state_q == ST_READY) & ~hold & sel & (pend_q | io.ioctl_rd);
  assign ram_rd   = serve & in_range;
  assign ram_addr = ram_rd ? (BASE + req_addr[AW-1:0]) : ram_addr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    wait_d      = wait_q;
    din_d       = din_q;
    acq         = 1'b0;
    own         = 1'b0;
    rel         = 1'b0;
    done        = 1'b0;
    if (state_q != ST_IDLE && state_q != ST_RELEASE && !sel) begin
      state_d = ST_RELEASE;
      rel     = 1'b1;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel) begin
            state_d = ST_PAUSE;
            acq     = 1'b1;
            wait_d  = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (io.ioctl_rd) begin
            pend_d      = 1'b1;
            pend_addr_d = io.ioctl_addr;
          end
          if (paused) begin
            own     = 1'b1;
            wait_d  = 1'b0;
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (hold) begin
            wait_d = 1'b1;
            if (io.ioctl_rd) begin
              pend_d      = 1'b1;
              pend_addr_d = io.ioctl_addr;
            end
          end else if (serve) begin
            pend_d = pend_q & io.ioctl_rd;
            if (pend_q && io.ioctl_rd) pend_addr_d = io.ioctl_addr;
            if (in_range) begin
              wait_d  = 1'b1;
              cnt_d   = '0;
              state_d = ST_FETCH;
            end else begin
              din_d  = FILL_BYTE;
              wait_d = 1'b0;
            end
          end else begin
            wait_d = 1'b0;
          end
        end
        ST_FETCH, ST_LAT: begin
          if (io.ioctl_rd) begin
            pend_d      = 1'b1;
            pend_addr_d = io.ioctl_addr;
          end
          if (hold) begin
            wait_d = 1'b1;
          end else if (cnt_q == CW'(RD_LAT - 1)) begin
            din_d   = ram_data;
            wait_d  = 1'b0;
            state_d = ST_READY;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_LAT;
          end
        end
        ST_RELEASE: begin
          done    = 1'b1;
          wait_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      wait_q      <= 1'b0;
      din_q       <= 8'h00;
      ram_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      wait_q      <= wait_d;
      din_q       <= din_d;
      ram_addr_q  <= ram_addr;
    end
  end

  upload_pause_arb u_arb (
    .clk_i        (clk_sys),
    .rst_i        (reset),
    .acq_i        (acq),
    .own_i        (own),
    .rel_i        (rel),
    .done_i       (done),
    .paused_i     (paused),
    .pause_req_o  (pause_req),
    .ram_access_o (ram_access),
    .hold_o       (hold)
  );

  assign io.ioctl_din  = din_q;
  assign io.ioctl_wait = wait_q;

`ifdef UPLOAD_DIRTY_REQ_EN
  localparam logic [AW:0] LEN_W = (AW+1)'(LEN);

  logic          dirty_q, granted_q, dirty_set;
  logic [AW-1:0] cpu_off;

  // Offset compare handles the window wrapping past the top of the address space.
  assign cpu_off   = cpu_addr - BASE;
  assign dirty_set = cpu_wr & ~ram_access & ({1'b0, cpu_off} < LEN_W);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dirty_q   <= 1'b0;
      granted_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) granted_q <= 1'b0;
      else if (own)           granted_q <= 1'b1;
      if (dirty_set)              dirty_q <= 1'b1;
      else if (done && granted_q) dirty_q <= 1'b0;
    end
  end

  assign ioctl_upload_req = dirty_q & ~io.ioctl_upload;
`endif

endmodule
